// File: rtl/uart_pkg.sv
// Shared UART constants: oversampling ratio, sample phases, receiver state encoding
// and the prescaler divisor computation.
package uart_pkg;

  localparam int         OVS        = 16;
  localparam logic [3:0] SAMPLE_PH0 = 4'd7;
  localparam logic [3:0] SAMPLE_PH1 = 4'd8;
  localparam logic [3:0] SAMPLE_PH2 = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRKWAIT
  } rx_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clkfreq, input int baud);
    return clkfreq / (OVS * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head is kept in a register so it holds its
// last value when the FIFO drains and reads as zero after reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q, rd_nxt;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_q + AW'(1);
  assign dout    = dout_q;
  assign count   = cnt_q;

  always_comb begin
    cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_d = dout_q;
    if (do_pop) begin
      if (cnt_q > (AW+1)'(1)) dout_d = mem_q[rd_nxt];
      else if (do_push)       dout_d = din;
    end else if (empty && do_push) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      if (do_pop)  rd_q <= rd_nxt;
      if (do_push) wr_q <= wr_q + AW'(1);
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver with majority-vote sampling, framing/break
// detection and a show-ahead receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKFREQ    = 30000000,
  parameter int BAUD       = 921600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  input  logic                        rd,
  input  logic                        clr_err,
  output logic                        valid,
  output logic [7:0]                  rx_data,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        break_det
);

  localparam int DIV = calc_div(CLKFREQ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_fifo: CLKFREQ too low for 16x oversampling at BAUD");
  end

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      ph_q, ph_d, ph_nxt, hi_q, hi_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            s0_q, s0_d, s1_q, s1_d;
  logic            frame_err_q, frame_err_d, overrun_q, overrun_d, break_q, break_d;
  logic            tick, decide, maj, push, set_fe, fifo_full, fifo_empty;

  assign tick   = (div_q == DW'(DIV - 1));
  assign ph_nxt = ph_q + 4'd1;
  assign decide = tick && (ph_nxt == SAMPLE_PH2);
  assign maj    = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    ph_d    = tick ? ph_nxt : ph_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    hi_d    = hi_q;
    break_d = 1'b0;
    push    = 1'b0;
    set_fe  = 1'b0;
    if (tick && ph_nxt == SAMPLE_PH0) s0_d = rx_sync_q;
    if (tick && ph_nxt == SAMPLE_PH1) s1_d = rx_sync_q;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          div_d   = '0;
          ph_d    = '0;
        end
      end
      START: begin
        if (decide) begin
          state_d = maj ? IDLE : DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (decide) begin
          shreg_d = {maj, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving mid-stop-bit lets the next start edge be caught immediately.
        if (decide) begin
          state_d = IDLE;
          if (maj) begin
            push = 1'b1;
          end else begin
            set_fe = 1'b1;
            if (shreg_q == 8'h00) begin
              break_d = 1'b1;
              hi_d    = '0;
              state_d = BRKWAIT;
            end
          end
        end
      end
      BRKWAIT: begin
        if (tick) begin
          if (!rx_sync_q)        hi_d = '0;
          else if (hi_q == 4'd15) state_d = IDLE;
          else                   hi_d = hi_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_err_d = (frame_err_q & ~clr_err) | set_fe;
    overrun_d   = (overrun_q & ~clr_err) | (push & fifo_full & ~rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      div_q       <= '0;
      ph_q        <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      hi_q        <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      div_q       <= div_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      hi_q        <= hi_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      break_q     <= break_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg_q),
    .pop   (rd),
    .dout  (rx_data),
    .count (rx_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign valid     = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign break_det = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=10 (160 clocks per bit); expected
// values are hand-derived from frame timing and FIFO behaviour.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rx, rd, clr_err;
  logic       valid, frame_err, overrun, break_det;
  logic [7:0] rx_data;
  logic [4:0] rx_count;

  int   total = 0, bad = 0, brk_cnt = 0, brk_base;
  logic v1500, v1560;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKFREQ(1600000), .BAUD(10000), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .valid     (valid),
    .rx_data   (rx_data),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .break_det (break_det)
  );

  always @(negedge clk) if (break_det) brk_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 1600-clock frame; optional inverted 10-clock glitch mid data bit,
  // optional one-cycle rd / reset at a given clock offset within the frame.
  task automatic send(input logic [7:0] b, input logic stopv, input int glitch_bit,
                      input int rd_at, input int rst_at);
    for (int c = 0; c < 1600; c++) begin
      int   bi;
      int   off;
      logic v;
      bi  = c / 160;
      off = c % 160;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stopv;
      else              v = b[bi-1];
      if (bi >= 1 && bi <= 8 && bi - 1 == glitch_bit && off >= 75 && off < 85) v = ~v;
      rx    = v;
      rd    = (c == rd_at);
      reset = (c == rst_at);
      if (c == 1500) v1500 = valid;
      if (c == 1560) v1560 = valid;
      @(negedge clk);
    end
    rx    = 1'b1;
    rd    = 1'b0;
    reset = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    rx = 1'b1; rd = 1'b0; clr_err = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_brk", break_det, 0);

    // clean frame and first-byte latency
    send(8'h55, 1'b1, -1, -1, -1);
    chk("lat_early", v1500, 0);
    chk("lat_late", v1560, 1);
    chk("clean_data", rx_data, 8'h55);
    chk("clean_count", rx_count, 1);
    pop();
    chk("pop_valid", valid, 0);
    chk("pop_count", rx_count, 0);
    chk("pop_hold", rx_data, 8'h55);

    // false start
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    chk("false_valid", valid, 0);
    chk("false_fe", frame_err, 0);

    // glitch on bit 1 rejected by majority vote
    send(8'hA5, 1'b1, 1, -1, -1);
    chk("glitch_data", rx_data, 8'hA5);
    chk("glitch_count", rx_count, 1);
    pop();

    // framing error
    brk_base = brk_cnt;
    send(8'hA5, 1'b0, -1, -1, -1);
    repeat (20) @(negedge clk);
    chk("fe_set", frame_err, 1);
    chk("fe_valid", valid, 0);
    chk("fe_nobrk", brk_cnt - brk_base, 0);
    clr();
    chk("fe_clr", frame_err, 0);

    // line break
    brk_base = brk_cnt;
    rx = 1'b0;
    repeat (3200) @(negedge clk);
    rx = 1'b1;
    repeat (320) @(negedge clk);
    chk("brk_pulses", brk_cnt - brk_base, 1);
    chk("brk_fe", frame_err, 1);
    chk("brk_valid", valid, 0);
    clr();
    send(8'h3C, 1'b1, -1, -1, -1);
    chk("brk_after", rx_data, 8'h3C);
    chk("brk_after_cnt", rx_count, 1);
    pop();

    // overflow: 17 frames, 0x10 dropped
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, -1, -1, -1);
    chk("ovf_count", rx_count, 16);
    chk("ovf_flag", overrun, 1);
    chk("ovf_head", rx_data, 8'h00);
    clr();
    chk("ovf_clr", overrun, 0);

    // full FIFO, pop coincides with push of 0x10 (push lands at clock 1532)
    send(8'h10, 1'b1, -1, 1532, -1);
    chk("pp_ov", overrun, 0);
    chk("pp_count", rx_count, 16);
    for (int i = 1; i <= 16; i++) begin
      chk("drain", rx_data, i);
      pop();
    end
    chk("drain_valid", valid, 0);
    chk("drain_count", rx_count, 0);

    // reset mid-frame
    send(8'h22, 1'b0, -1, -1, -1);
    send(8'h44, 1'b1, -1, -1, -1);
    chk("pre_rst_fe", frame_err, 1);
    send(8'hFF, 1'b1, -1, -1, 880);
    chk("mrst_valid", valid, 0);
    chk("mrst_data", rx_data, 0);
    chk("mrst_count", rx_count, 0);
    chk("mrst_fe", frame_err, 0);
    chk("mrst_ov", overrun, 0);
    chk("mrst_brk", break_det, 0);
    send(8'h81, 1'b1, -1, -1, -1);
    chk("post_data", rx_data, 8'h81);
    chk("post_count", rx_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Robust receive end for the existing transmitter (`uart`). It is a higher-quality replacement for the minimal `rxuart` on the J1a I/O bus.
- Front end: 16x oversampling with a 2-flop synchroniser and 3-sample majority vote.
- Detects framing errors and line break.
- Buffers received bytes in a show-ahead FIFO so the CPU can tolerate burst input at 921600 baud.

Parameters:
- CLKFREQ, 30000000, frequency of clk in Hz.
- BAUD, 921600, line rate in bit/s.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- rd  in  1  pop strobe; ignored when valid=0.
- clr_err  in  1  clears frame_err and overrun.
- valid  out  1  FIFO not empty.
- rx_data  out  8  FIFO head byte (show-ahead).
- rx_count  out  $clog2(FIFO_DEPTH)+1  bytes currently held.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- break_det  out  1  one-cycle pulse per detected break.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - Synchroniser flops to 1; state IDLE.
  - valid=0, rx_data=0, rx_count=0, frame_err=0, overrun=0, break_det=0.
  - A partial frame in progress is discarded.
- Tick generator:
  - DIV = CLKFREQ/(16*BAUD), integer-truncated; DIV must be >=1 (elaboration error otherwise).
  - One tick every DIV clocks. The prescaler restarts on start-edge detection.
- Bit phase counter:
  - 4-bit, 0..15, advances on each tick and wraps 15->0; one wrap = one bit time.
  - Cleared on start-edge detection.
- Sampling:
  - Synchronised rx is captured at phases 7, 8 and 9.
  - The bit value is the majority of the three, decided on the phase-9 tick.
- States:
  - IDLE: a 1->0 transition on synchronised rx clears the counters and goes to START.
  - START: majority=1 is a false start and returns to IDLE. majority=0 goes to DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted in at each phase-9 decision. After bit 7, go to STOP.
  - STOP:
    - majority=1: push the byte and go to IDLE. IDLE is re-entered mid-stop-bit so back-to-back frames are accepted.
    - majority=0 and byte==0x00: frame_err set, no push, break_det pulses 1 cycle, go to BRKWAIT.
    - majority=0 and byte!=0x00: frame_err set, no push, go to IDLE.
  - BRKWAIT: stay until synchronised rx has been 1 for 16 consecutive ticks, then go to IDLE. No start detection happens in this state.
- Latency: a pushed byte makes valid=1 on the clock edge after the phase-9 decision of the stop bit.
- FIFO:
  - Show-ahead: rx_data always shows the head; it holds its last value when empty.
  - Pop happens when rd && valid. rd on empty has no effect.
  - Push when full (without a simultaneous pop): byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle:
    - When full: both succeed, no overrun, count unchanged.
    - When empty: push only; pop ignored.
  - Pointers wrap modulo FIFO_DEPTH. rx_count is in 0..FIFO_DEPTH.
- Sticky flags: clr_err clears them. A new error in the same cycle as clr_err wins (flag stays 1).

Decomposition:
- Shared package `uart_pkg`:
  - OVS=16, SAMPLE_PH0/1/2 = 7/8/9.
  - State encoding IDLE/START/DATA/STOP/BRKWAIT.
  - DIV computation function, shared with a future 16x transmitter.
- One sub-module, `sync_fifo`: parameters WIDTH, DEPTH; ports clk, reset, push, din, pop, dout, count, full, empty; show-ahead.
- Synchroniser, tick generator and FSM stay in uart_rx_fifo.

Test Plan:
All scenarios use CLKFREQ=1600000 and BAUD=10000, so DIV=10 and a bit time is 160 clocks.
- Clean frame 0x55 -> valid rises about 1520 clocks after the start edge; rx_data=0x55, rx_count=1. rd for 1 cycle -> valid=0, rx_count=0.
- Glitches:
  - rx low for 30 clocks while IDLE -> false start; no byte, frame_err=0.
  - Frame 0xA5 with a 10-clock high glitch centred on phase 8 of bit 1 -> rx_data=0xA5, because the majority vote rejects the glitch.
- Frame 0xA5 with stop bit low -> frame_err=1, valid=0. clr_err -> frame_err=0.
- Line low for 20 bit times -> exactly one break_det pulse, frame_err=1, no byte. After 2 idle bit times, frame 0x3C -> rx_data=0x3C.
- 17 back-to-back frames 0x00..0x10 with no reads -> rx_count=16, overrun=1. Popping drains 0x00..0x0F in order; 0x10 is lost.
- FIFO full, with rd pulsed on the cycle 0x10 is pushed -> overrun stays 0, rx_count=16, last entry=0x10.
- reset pulsed for 1 cycle during bit 4 of frame 0xFF -> all outputs at reset values. The next frame 0x81 -> rx_data=0x81, rx_count=1.
